// File: rtl/io_port_ctrl_pkg.sv
// io_port_ctrl_pkg: shared interrupt FSM encoding and a constant clog2 helper
package io_port_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: external source/sink handshakes and processor-side I/O signals
interface io_port_ctrl_if #(parameter int W = 16);
  logic         ext_in_valid;
  logic [W-1:0] ext_in_data;
  logic         ext_in_ready;
  logic [W-1:0] in_port;
  logic         in_rd;
  logic         interrupt;
  logic [W-1:0] out_port;
  logic         out_wr;
  logic         ext_out_valid;
  logic [W-1:0] ext_out_data;
  logic         ext_out_ready;
  logic         in_empty;
  logic         out_ovf;
  modport slave (
    input  ext_in_valid, ext_in_data, in_rd, out_port, out_wr, ext_out_ready,
    output ext_in_ready, in_port, interrupt, ext_out_valid, ext_out_data, in_empty, out_ovf
  );
  modport master (
    output ext_in_valid, ext_in_data, in_rd, out_port, out_wr, ext_out_ready,
    input  ext_in_ready, in_port, interrupt, ext_out_valid, ext_out_data, in_empty, out_ovf
  );
endinterface

// File: rtl/io_port_ctrl_sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with combinational head; caller gates push/pop
module sync_fifo
  import io_port_ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic [W-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    dout  = mem_q[rptr_q];
    full  = cnt_q == FULL;
    empty = cnt_q == '0;
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= din;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: buffered processor I/O port with overflow flag and one-shot input interrupt
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEPTH     = 4,
  parameter int INT_PULSE = 2
) (
  input logic          clk,
  input logic          rst,
  io_port_ctrl_if.slave bus
);
  localparam int CW = clog2(DEPTH) + 1;
  localparam int PW = clog2(INT_PULSE) + 1;
  localparam logic [PW-1:0] PLOAD = PW'(INT_PULSE - 1);
  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [W-1:0]  in_dout, out_dout, hold_q, hold_d;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          ovf_q, ovf_d, unused_cnt;
  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  assign unused_cnt = ^{in_cnt, out_cnt};
  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_in (
    .clk, .rst, .push(in_push), .din(bus.ext_in_data), .pop(in_pop),
    .dout(in_dout), .full(in_full), .empty(in_empty), .count(in_cnt)
  );
  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_out (
    .clk, .rst, .push(out_push), .din(bus.out_port), .pop(out_pop),
    .dout(out_dout), .full(out_full), .empty(out_empty), .count(out_cnt)
  );
  // A full output FIFO still takes a write when the sink frees a slot that same cycle
  always_comb begin
    in_push  = bus.ext_in_valid & ~in_full;
    in_pop   = bus.in_rd & ~in_empty;
    out_pop  = bus.ext_out_ready & ~out_empty;
    out_push = bus.out_wr & (~out_full | out_pop);
    hold_d   = in_pop ? in_dout : hold_q;
    ovf_d    = ovf_q | (bus.out_wr & ~out_push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE:    if (!in_empty) begin state_d = PULSE; pcnt_d = PLOAD; end
      PULSE:   if (pcnt_q == '0) state_d = WAIT; else pcnt_d = pcnt_q - 1'b1;
      WAIT:    if (in_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.interrupt     = state_q == PULSE;
    bus.ext_in_ready  = ~in_full;
    bus.in_port       = in_empty ? hold_q : in_dout;
    bus.in_empty      = in_empty;
    bus.ext_out_valid = ~out_empty;
    bus.ext_out_data  = out_empty ? '0 : out_dout;
    bus.out_ovf       = ovf_q;
  end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed scenario tests for io_port_ctrl
module tb_io_port_ctrl;
  import io_port_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int int_cycles = 0;
  io_port_ctrl_if #(.W(16)) bus();
  io_port_ctrl #(.W(16), .DEPTH(4), .INT_PULSE(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.interrupt === 1'b1) int_cycles++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.ext_in_valid = 0; bus.ext_in_data = 0; bus.in_rd = 0;
    bus.out_port = 0; bus.out_wr = 0; bus.ext_out_ready = 0;
    rst = 1; tick(); tick(); rst = 0;
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL rst_interrupt: got %b want 0", bus.interrupt); end
    checks++; if (bus.in_port !== 16'h0) begin errors++; $display("FAIL rst_in_port: got %h want 0000", bus.in_port); end
    checks++; if (bus.in_empty !== 1'b1) begin errors++; $display("FAIL rst_in_empty: got %b want 1", bus.in_empty); end
    checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.ext_out_valid); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf: got %b want 0", bus.out_ovf); end
    checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.ext_in_ready); end
    checks++; if (bus.ext_out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", bus.ext_out_data); end
  endtask
  task automatic test_single_input();
    int_cycles = 0;
    bus.ext_in_valid = 1; bus.ext_in_data = 16'h00A5; tick(); bus.ext_in_valid = 0;
    checks++; if (bus.in_port !== 16'h00A5) begin errors++; $display("FAIL single_in_port: got %h want 00a5", bus.in_port); end
    checks++; if (bus.in_empty !== 1'b0) begin errors++; $display("FAIL single_in_empty: got %b want 0", bus.in_empty); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (int_cycles !== 2) begin errors++; $display("FAIL single_int_cycles: got %0d want 2", int_cycles); end
    bus.in_rd = 1; tick(); bus.in_rd = 0;
    checks++; if (bus.in_empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b want 1", bus.in_empty); end
    checks++; if (bus.in_port !== 16'h00A5) begin errors++; $display("FAIL single_hold: got %h want 00a5", bus.in_port); end
    tick();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL single_fsm_idle: got %0d want %0d", dut.state_q, IDLE); end
    bus.in_rd = 1; tick(); bus.in_rd = 0;
    checks++; if (bus.in_port !== 16'h00A5) begin errors++; $display("FAIL empty_rd_hold: got %h want 00a5", bus.in_port); end
    checks++; if (int_cycles !== 2) begin errors++; $display("FAIL single_no_retrigger: got %0d want 2", int_cycles); end
  endtask
  task automatic test_input_full();
    int_cycles = 0;
    for (int k = 1; k <= 4; k++) begin bus.ext_in_valid = 1; bus.ext_in_data = 16'(k); tick(); end
    checks++; if (bus.ext_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.ext_in_ready); end
    checks++; if (bus.in_port !== 16'h1) begin errors++; $display("FAIL full_head: got %h want 0001", bus.in_port); end
    bus.ext_in_data = 16'h5; bus.in_rd = 1; tick(); bus.ext_in_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      checks++; if (bus.in_port !== 16'(k)) begin errors++; $display("FAIL full_seq: got %h want %h", bus.in_port, 16'(k)); end
      tick();
    end
    bus.in_rd = 0;
    checks++; if (bus.in_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", bus.in_empty); end
    checks++; if (bus.in_port !== 16'h4) begin errors++; $display("FAIL full_no_5: got %h want 0004", bus.in_port); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (int_cycles !== 2) begin errors++; $display("FAIL full_one_pulse: got %0d want 2", int_cycles); end
  endtask
  task automatic test_output_path();
    bus.ext_out_ready = 0; bus.out_wr = 1; bus.out_port = 16'h1111; tick();
    checks++; if (bus.ext_out_valid !== 1'b1) begin errors++; $display("FAIL out_latency: got %b want 1", bus.ext_out_valid); end
    bus.out_port = 16'h2222; tick(); bus.out_wr = 0; tick();
    checks++; if (bus.ext_out_data !== 16'h1111) begin errors++; $display("FAIL out_stable: got %h want 1111", bus.ext_out_data); end
    bus.ext_out_ready = 1;
    checks++; if (bus.ext_out_data !== 16'h1111) begin errors++; $display("FAIL out_first: got %h want 1111", bus.ext_out_data); end
    tick();
    checks++; if (bus.ext_out_data !== 16'h2222) begin errors++; $display("FAIL out_second: got %h want 2222", bus.ext_out_data); end
    tick(); bus.ext_out_ready = 0;
    checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_drop: got %b want 0", bus.ext_out_valid); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL out_no_ovf: got %b want 0", bus.out_ovf); end
  endtask
  task automatic test_overflow();
    logic [15:0] exp [4];
    exp = '{16'h11, 16'h12, 16'h13, 16'h15};
    for (int k = 0; k < 5; k++) begin
      bus.out_wr = 1; bus.out_port = 16'(16'h10 + k); tick();
      if (k == 3) begin
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.out_ovf); end
      end
    end
    bus.out_wr = 0;
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.out_ovf); end
    checks++; if (bus.ext_out_data !== 16'h10) begin errors++; $display("FAIL ovf_head: got %h want 0010", bus.ext_out_data); end
    bus.out_wr = 1; bus.out_port = 16'h15; bus.ext_out_ready = 1; tick();
    bus.out_wr = 0; bus.ext_out_ready = 0; tick();
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.out_ovf); end
    bus.ext_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.ext_out_data !== exp[i]) begin errors++; $display("FAIL ovf_drain: got %h want %h", bus.ext_out_data, exp[i]); end
      tick();
    end
    bus.ext_out_ready = 0;
    checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", bus.ext_out_valid); end
  endtask
  task automatic test_reset_mid();
    bus.out_wr = 1; bus.out_port = 16'h3333; bus.ext_in_valid = 1;
    for (int k = 7; k <= 9; k++) begin bus.ext_in_data = 16'(k); tick(); bus.out_wr = 0; end
    bus.ext_in_valid = 0;
    checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL mid_int_high: got %b want 1", bus.interrupt); end
    rst = 1; tick(); rst = 0;
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL mid_interrupt: got %b want 0", bus.interrupt); end
    checks++; if (bus.in_empty !== 1'b1) begin errors++; $display("FAIL mid_in_empty: got %b want 1", bus.in_empty); end
    checks++; if (bus.in_port !== 16'h0) begin errors++; $display("FAIL mid_in_port: got %h want 0000", bus.in_port); end
    checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", bus.ext_out_valid); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL mid_out_ovf: got %b want 0", bus.out_ovf); end
    checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", bus.ext_in_ready); end
    int_cycles = 0;
    bus.ext_in_valid = 1; bus.ext_in_data = 16'h00AA; tick(); bus.ext_in_valid = 0;
    checks++; if (bus.in_port !== 16'h00AA) begin errors++; $display("FAIL mid_new_push: got %h want 00aa", bus.in_port); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (int_cycles !== 2) begin errors++; $display("FAIL mid_retrigger: got %0d want 2", int_cycles); end
    bus.in_rd = 1; tick(); tick();
    bus.ext_in_valid = 1; bus.ext_in_data = 16'h00BB; tick();
    bus.ext_in_valid = 0; bus.in_rd = 0;
    checks++; if (bus.in_empty !== 1'b0) begin errors++; $display("FAIL empty_pushpop_empty: got %b want 0", bus.in_empty); end
    checks++; if (bus.in_port !== 16'h00BB) begin errors++; $display("FAIL empty_pushpop_port: got %h want 00bb", bus.in_port); end
  endtask
  initial begin
    test_reset();
    test_single_input();
    test_input_full();
    test_output_path();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
